axi_mm_write_arbiter: RTL and testbench
=======================================

# axi_mm_write_arbiter

Two-port AXI4 write-channel arbiter that shares one `m_axi_mm_video` write port between two burst write engines (for example, two stream-to-memory burst engines for two video planes). It arbitrates at burst granularity with round-robin priority. Once a burst's address is granted, the W and B channels are locked to that requester until the write response completes. It sits between the burst engines and the memory-side AXI master port; the read channels are not touched.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: AW address width.
- `DATA_WIDTH`, 8: W data width; `WSTRB` width is `DATA_WIDTH/8`.

Ports (`N` = 0, 1; each `sN_` line covers both requesters):
- `ap_clk`, in, 1: clock.
- `ap_rst_n`, in, 1: reset, asynchronous, active-low.
- `sN_axi_awvalid` in 1 / `sN_axi_awready` out 1: requester AW handshake.
- `sN_axi_awaddr`, in, `ADDR_WIDTH`: burst start address.
- `sN_axi_awlen` in 8, `sN_axi_awsize` in 3, `sN_axi_awburst` in 2, `sN_axi_awprot` in 3: burst attributes.
- `sN_axi_wvalid` in 1 / `sN_axi_wready` out 1 / `sN_axi_wlast` in 1: requester W handshake.
- `sN_axi_wdata` in `DATA_WIDTH`, `sN_axi_wstrb` in `DATA_WIDTH/8`: write beat.
- `sN_axi_bvalid` out 1 / `sN_axi_bready` in 1 / `sN_axi_bresp` out 2: requester B channel.
- `m_axi_aw*`, `m_axi_w*`, `m_axi_b*`: same signals in the opposite direction, one shared set toward memory.
- `grant`, out, 2: one-hot owner of the shared port; 00 when idle.
- `busy`, out, 1: 1 in every state except IDLE.
- `err_sticky`, out, 1: set when any `m_axi_bresp` != 00 is accepted.

## Operation
- FSM states: IDLE, ADDR, DATA, RESP. The registered `grant` drives all muxes combinationally; there is no data buffering.
- IDLE:
  - Shared-port outputs: `m_axi_awvalid`=0, `m_axi_wvalid`=0, `m_axi_bready`=0.
  - If any `sN_axi_awvalid`=1, pick the requester that did not own the last burst; a lone requester always wins.
  - Register the one-hot `grant` and go to ADDR.
- ADDR:
  - All `m_axi_aw*` come from the granted requester; `m_axi_awready` is returned to it.
  - On `m_axi_awvalid & m_axi_awready`, go to DATA.
- DATA:
  - W channel is routed to the granted requester.
  - On `m_axi_wvalid & m_axi_wready & m_axi_wlast`, go to RESP.
  - No beat counting: the requester's `wlast` is trusted.
- RESP:
  - `m_axi_bready` = granted `bready`; `m_axi_bvalid`/`m_axi_bresp` are routed to the granted requester.
  - On B handshake: `last_owner` <= granted index, `grant` <= 00, go to IDLE.
- The non-granted requester (and both requesters in IDLE) sees `awready`=0, `wready`=0, `bvalid`=0, `bresp`=00.
- At most one burst is outstanding; a new AW is never issued before the previous B completes.
- `err_sticky` holds until reset.

## Timing
- Reset values:
  - All `m_axi_*` valid/ready outputs = 0; `m_axi` address, data and attribute outputs = 0 (mux default).
  - `grant`=00, `busy`=0, `err_sticky`=0, state IDLE.
  - `last_owner`=1, so requester 0 wins the first contention.
- Latency:
  - `awvalid` seen in IDLE at cycle n gives `m_axi_awvalid`=1 at cycle n+1.
  - Return to IDLE is the cycle after the B handshake.
  - Minimum occupancy per burst = 1 (IDLE) + 1 (ADDR, if AW accepted at once) + (`awlen`+1) W beats + 1 (RESP).
- Simultaneous requests: strict alternation; back-to-back bursts from both requesters interleave 0,1,0,1.
- `sN_axi_wvalid` asserted before its AW grant is stalled (`wready`=0) with no loss of data.
- `bvalid` arriving in the same cycle as `wlast` is accepted in RESP on the next cycle; the memory slave holds `bvalid` per AXI rules.
- Reset asserted mid-burst: immediate return to IDLE with all valids low; the partial burst is abandoned (system-level reset only).
- Deasserting `awvalid` before the handshake is an AXI violation and is unsupported.

## Test plan
- Single requester: s0 AW addr 0x1000, `awlen`=3, 4 beats 0x01..0x04, BRESP 00. Check `m_axi` shows the identical burst, `grant`=01 through RESP, s1 `awready`/`wready` held 0.
- Contention: s0 and s1 assert AW at the same cycle after reset. Check s0 is granted first, s1's burst (addr 0x2000) follows, then a third s0 request goes next (0,1,0 order).
- W stall: s1 drives `wvalid` with data 0xAA while s0 owns the port. Check s1 `wready`=0 until s1 is granted, and 0xAA appears on `m_axi_wdata` exactly once.
- Backpressure: memory holds `awready` low 5 cycles and `wready` low on every other beat, `awlen`=15. Check the 16 beats arrive in order with `wlast` on beat 16 only.
- Error and reset: BRESP=10 on an s1 burst. Check s1 sees `bresp`=10 and `err_sticky`=1. Then assert `ap_rst_n`=0 mid-DATA of the next burst and check all outputs return to reset values within the same cycle.

Source files
------------

// File: rtl/axi_mm_write_arbiter.sv
`default_nettype none
// axi_mm_write_arbiter: shares one AXI4 write port between two burst engines,
// round-robin per burst, with W and B locked to the AW winner until B completes.
module axi_mm_write_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 8
) (
   input  logic                    ap_clk,
   input  logic                    ap_rst_n,
   // requester 0
   input  logic                    s0_axi_awvalid,
   output logic                    s0_axi_awready,
   input  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr,
   input  logic [7:0]              s0_axi_awlen,
   input  logic [2:0]              s0_axi_awsize,
   input  logic [1:0]              s0_axi_awburst,
   input  logic [2:0]              s0_axi_awprot,
   input  logic                    s0_axi_wvalid,
   output logic                    s0_axi_wready,
   input  logic                    s0_axi_wlast,
   input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0] s0_axi_wstrb,
   output logic                    s0_axi_bvalid,
   input  logic                    s0_axi_bready,
   output logic [1:0]              s0_axi_bresp,
   // requester 1
   input  logic                    s1_axi_awvalid,
   output logic                    s1_axi_awready,
   input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
   input  logic [7:0]              s1_axi_awlen,
   input  logic [2:0]              s1_axi_awsize,
   input  logic [1:0]              s1_axi_awburst,
   input  logic [2:0]              s1_axi_awprot,
   input  logic                    s1_axi_wvalid,
   output logic                    s1_axi_wready,
   input  logic                    s1_axi_wlast,
   input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0] s1_axi_wstrb,
   output logic                    s1_axi_bvalid,
   input  logic                    s1_axi_bready,
   output logic [1:0]              s1_axi_bresp,
   // shared memory-side port
   output logic                    m_axi_awvalid,
   input  logic                    m_axi_awready,
   output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [7:0]              m_axi_awlen,
   output logic [2:0]              m_axi_awsize,
   output logic [1:0]              m_axi_awburst,
   output logic [2:0]              m_axi_awprot,
   output logic                    m_axi_wvalid,
   input  logic                    m_axi_wready,
   output logic                    m_axi_wlast,
   output logic [DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
   input  logic                    m_axi_bvalid,
   output logic                    m_axi_bready,
   input  logic [1:0]              m_axi_bresp,
   // status
   output logic [1:0]              grant,
   output logic                    busy,
   output logic                    err_sticky
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t     state;
   state_t     state_next;
   logic [1:0] grant_next;
   logic       last_owner;
   logic       last_owner_next;

   logic       in_addr;
   logic       in_data;
   logic       in_resp;
   logic       sel_awvalid;
   logic       sel_wvalid;
   logic       sel_bready;
   logic       aw_hs;
   logic       w_last_hs;
   logic       b_hs;

   assign in_addr = (state == ADDR);
   assign in_data = (state == DATA);
   assign in_resp = (state == RESP);

   // Registered grant steers every shared-port field; no grant means all zero.
   always_comb begin
      m_axi_awaddr  = '0;
      m_axi_awlen   = '0;
      m_axi_awsize  = '0;
      m_axi_awburst = '0;
      m_axi_awprot  = '0;
      m_axi_wdata   = '0;
      m_axi_wstrb   = '0;
      m_axi_wlast   = 1'b0;
      sel_awvalid   = 1'b0;
      sel_wvalid    = 1'b0;
      sel_bready    = 1'b0;
      if (grant[0]) begin
         m_axi_awaddr  = s0_axi_awaddr;
         m_axi_awlen   = s0_axi_awlen;
         m_axi_awsize  = s0_axi_awsize;
         m_axi_awburst = s0_axi_awburst;
         m_axi_awprot  = s0_axi_awprot;
         m_axi_wdata   = s0_axi_wdata;
         m_axi_wstrb   = s0_axi_wstrb;
         m_axi_wlast   = s0_axi_wlast;
         sel_awvalid   = s0_axi_awvalid;
         sel_wvalid    = s0_axi_wvalid;
         sel_bready    = s0_axi_bready;
      end else if (grant[1]) begin
         m_axi_awaddr  = s1_axi_awaddr;
         m_axi_awlen   = s1_axi_awlen;
         m_axi_awsize  = s1_axi_awsize;
         m_axi_awburst = s1_axi_awburst;
         m_axi_awprot  = s1_axi_awprot;
         m_axi_wdata   = s1_axi_wdata;
         m_axi_wstrb   = s1_axi_wstrb;
         m_axi_wlast   = s1_axi_wlast;
         sel_awvalid   = s1_axi_awvalid;
         sel_wvalid    = s1_axi_wvalid;
         sel_bready    = s1_axi_bready;
      end
   end

   // Each channel is only open in its own phase of the burst.
   assign m_axi_awvalid = in_addr & sel_awvalid;
   assign m_axi_wvalid  = in_data & sel_wvalid;
   assign m_axi_bready  = in_resp & sel_bready;

   assign aw_hs     = m_axi_awvalid & m_axi_awready;
   assign w_last_hs = m_axi_wvalid & m_axi_wready & m_axi_wlast;
   assign b_hs      = m_axi_bvalid & m_axi_bready;

   assign s0_axi_awready = grant[0] & in_addr & m_axi_awready;
   assign s1_axi_awready = grant[1] & in_addr & m_axi_awready;
   assign s0_axi_wready  = grant[0] & in_data & m_axi_wready;
   assign s1_axi_wready  = grant[1] & in_data & m_axi_wready;
   assign s0_axi_bvalid  = grant[0] & in_resp & m_axi_bvalid;
   assign s1_axi_bvalid  = grant[1] & in_resp & m_axi_bvalid;
   assign s0_axi_bresp   = (grant[0] & in_resp) ? m_axi_bresp : 2'b00;
   assign s1_axi_bresp   = (grant[1] & in_resp) ? m_axi_bresp : 2'b00;

   always_comb begin
      state_next      = state;
      grant_next      = grant;
      last_owner_next = last_owner;
      case (state)
         IDLE: begin
            if (s0_axi_awvalid | s1_axi_awvalid) begin
               // Requester 0 wins unless requester 1 is also asking and 0 went last.
               if (s0_axi_awvalid & (~s1_axi_awvalid | last_owner)) begin
                  grant_next = 2'b01;
               end else begin
                  grant_next = 2'b10;
               end
               state_next = ADDR;
            end
         end
         ADDR: begin
            if (aw_hs) begin
               state_next = DATA;
            end
         end
         DATA: begin
            if (w_last_hs) begin
               state_next = RESP;
            end
         end
         RESP: begin
            if (b_hs) begin
               last_owner_next = grant[1];
               grant_next      = 2'b00;
               state_next      = IDLE;
            end
         end
         default: begin
            grant_next = 2'b00;
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state      <= IDLE;
         grant      <= 2'b00;
         last_owner <= 1'b1;
         err_sticky <= 1'b0;
      end else begin
         state      <= state_next;
         grant      <= grant_next;
         last_owner <= last_owner_next;
         if (b_hs && (m_axi_bresp != 2'b00)) begin
            err_sticky <= 1'b1;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_axi_mm_write_arbiter.sv
`default_nettype none
// tb_axi_mm_write_arbiter: directed phases plus randomized bursts, checked against
// a burst-order model of round-robin arbitration and an in-order beat scoreboard.
module tb_axi_mm_write_arbiter;

   logic ap_clk = 1'b0;
   logic ap_rst_n = 1'b0;
   always #5 ap_clk = ~ap_clk;

   logic s0_axi_awvalid, s0_axi_awready, s0_axi_wvalid, s0_axi_wready, s0_axi_wlast;
   logic s0_axi_bvalid, s0_axi_bready;
   logic [31:0] s0_axi_awaddr;
   logic [7:0] s0_axi_awlen, s0_axi_wdata;
   logic [2:0] s0_axi_awsize, s0_axi_awprot;
   logic [1:0] s0_axi_awburst, s0_axi_bresp;
   logic [0:0] s0_axi_wstrb;
   logic s1_axi_awvalid, s1_axi_awready, s1_axi_wvalid, s1_axi_wready, s1_axi_wlast;
   logic s1_axi_bvalid, s1_axi_bready;
   logic [31:0] s1_axi_awaddr;
   logic [7:0] s1_axi_awlen, s1_axi_wdata;
   logic [2:0] s1_axi_awsize, s1_axi_awprot;
   logic [1:0] s1_axi_awburst, s1_axi_bresp;
   logic [0:0] s1_axi_wstrb;
   logic m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready, m_axi_wlast;
   logic m_axi_bvalid, m_axi_bready;
   logic [31:0] m_axi_awaddr;
   logic [7:0] m_axi_awlen, m_axi_wdata;
   logic [2:0] m_axi_awsize, m_axi_awprot;
   logic [1:0] m_axi_awburst, m_axi_bresp;
   logic [0:0] m_axi_wstrb;
   logic [1:0] grant;
   logic busy, err_sticky;

   axi_mm_write_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(8)) dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
      .s0_axi_awvalid(s0_axi_awvalid), .s0_axi_awready(s0_axi_awready), .s0_axi_awaddr(s0_axi_awaddr),
      .s0_axi_awlen(s0_axi_awlen), .s0_axi_awsize(s0_axi_awsize), .s0_axi_awburst(s0_axi_awburst),
      .s0_axi_awprot(s0_axi_awprot), .s0_axi_wvalid(s0_axi_wvalid), .s0_axi_wready(s0_axi_wready),
      .s0_axi_wlast(s0_axi_wlast), .s0_axi_wdata(s0_axi_wdata), .s0_axi_wstrb(s0_axi_wstrb),
      .s0_axi_bvalid(s0_axi_bvalid), .s0_axi_bready(s0_axi_bready), .s0_axi_bresp(s0_axi_bresp),
      .s1_axi_awvalid(s1_axi_awvalid), .s1_axi_awready(s1_axi_awready), .s1_axi_awaddr(s1_axi_awaddr),
      .s1_axi_awlen(s1_axi_awlen), .s1_axi_awsize(s1_axi_awsize), .s1_axi_awburst(s1_axi_awburst),
      .s1_axi_awprot(s1_axi_awprot), .s1_axi_wvalid(s1_axi_wvalid), .s1_axi_wready(s1_axi_wready),
      .s1_axi_wlast(s1_axi_wlast), .s1_axi_wdata(s1_axi_wdata), .s1_axi_wstrb(s1_axi_wstrb),
      .s1_axi_bvalid(s1_axi_bvalid), .s1_axi_bready(s1_axi_bready), .s1_axi_bresp(s1_axi_bresp),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
      .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
      .m_axi_awprot(m_axi_awprot), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_wlast(m_axi_wlast), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
      .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
      .grant(grant), .busy(busy), .err_sticky(err_sticky)
   );

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic [2:0]  prot;
      logic [1:0]  resp;
   } burst_t;

   typedef struct {
      logic [7:0] data;
      logic       strb;
      logic       last;
   } beat_t;

   int checks = 0;
   int errors = 0;

   burst_t awq0[$], awq1[$], st0[$], st1[$], exp_aw[$];
   beat_t  wq0[$], wq1[$], sb0[$], sb1[$], exp_w[$];
   logic [1:0] exp_b0[$], exp_b1[$], got_b0[$], got_b1[$], resp_tbl[$], exp_grant[$];
   int   model_last = 1;
   logic model_err = 1'b0;
   logic bp_mode = 1'b0;
   int   aw_hold = 0;
   int   pending_b = 0;
   int   beats_seen = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic add_burst(input int n, input logic [31:0] addr, input logic [7:0] len,
                            input logic [7:0] base, input logic [1:0] resp, input bit rnd);
      burst_t b;
      beat_t  w;
      b.addr  = addr;
      b.len   = len;
      b.size  = rnd ? 3'($urandom_range(0, 7)) : 3'd0;
      b.burst = rnd ? 2'($urandom_range(0, 3)) : 2'b01;
      b.prot  = rnd ? 3'($urandom_range(0, 7)) : 3'd0;
      b.resp  = resp;
      if (n == 0) st0.push_back(b); else st1.push_back(b);
      for (int k = 0; k <= int'(len); k++) begin
         w.data = rnd ? 8'($urandom_range(0, 255)) : 8'(int'(base) + k);
         w.strb = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         w.last = (k == int'(len));
         if (n == 0) sb0.push_back(w); else sb1.push_back(w);
      end
   endtask

   // Order model: whichever requester still has bursts pending competes; when both
   // do, the one that did not own the previous burst goes next.
   task automatic commit();
      int i0, i1, p0, p1, owner;
      burst_t b;
      i0 = 0; i1 = 0; p0 = 0; p1 = 0;
      while (i0 < st0.size() || i1 < st1.size()) begin
         if (i0 < st0.size() && i1 < st1.size()) owner = (model_last == 1) ? 0 : 1;
         else owner = (i0 < st0.size()) ? 0 : 1;
         b = (owner == 1) ? st1[i1] : st0[i0];
         exp_aw.push_back(b);
         exp_grant.push_back((owner == 1) ? 2'b10 : 2'b01);
         resp_tbl.push_back(b.resp);
         if (owner == 1) exp_b1.push_back(b.resp); else exp_b0.push_back(b.resp);
         if (b.resp != 2'b00) model_err = 1'b1;
         for (int k = 0; k <= int'(b.len); k++) begin
            if (owner == 1) begin exp_w.push_back(sb1[p1]); p1++; end
            else begin exp_w.push_back(sb0[p0]); p0++; end
         end
         model_last = owner;
         if (owner == 1) i1++; else i0++;
      end
      foreach (st0[i]) awq0.push_back(st0[i]);
      foreach (st1[i]) awq1.push_back(st1[i]);
      foreach (sb0[i]) wq0.push_back(sb0[i]);
      foreach (sb1[i]) wq1.push_back(sb1[i]);
      st0.delete(); st1.delete(); sb0.delete(); sb1.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_m_awvalid"}, m_axi_awvalid, 0);
      check({tag, "_m_wvalid"},  m_axi_wvalid, 0);
      check({tag, "_m_bready"},  m_axi_bready, 0);
      check({tag, "_m_awaddr"},  m_axi_awaddr, 0);
      check({tag, "_m_awlen"},   m_axi_awlen, 0);
      check({tag, "_m_wdata"},   m_axi_wdata, 0);
      check({tag, "_m_wlast"},   m_axi_wlast, 0);
      check({tag, "_grant"},     grant, 0);
      check({tag, "_busy"},      busy, 0);
      check({tag, "_err"},       err_sticky, 0);
      check({tag, "_s_ready"},   {s0_axi_awready, s0_axi_wready, s1_axi_awready, s1_axi_wready}, 0);
      check({tag, "_s_bvalid"},  {s0_axi_bvalid, s1_axi_bvalid, s0_axi_bresp, s1_axi_bresp}, 0);
   endtask

   task automatic clear_model();
      exp_aw.delete(); exp_w.delete(); exp_grant.delete(); resp_tbl.delete();
      exp_b0.delete(); exp_b1.delete(); got_b0.delete(); got_b1.delete();
      model_last = 1;
      model_err = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string tag);
      int n;
      n = 0;
      while (n < budget && !(exp_aw.size() == 0 && exp_w.size() == 0 &&
             got_b0.size() == exp_b0.size() && got_b1.size() == exp_b1.size())) begin
         @(negedge ap_clk);
         n++;
      end
      check({tag, "_complete"}, (n < budget), 1);
      check({tag, "_idle_busy"}, busy, 0);
      check({tag, "_idle_grant"}, grant, 0);
      foreach (exp_b0[i]) check({tag, "_bresp0"}, (i < got_b0.size()) ? got_b0[i] : 2'bxx, exp_b0[i]);
      foreach (exp_b1[i]) check({tag, "_bresp1"}, (i < got_b1.size()) ? got_b1[i] : 2'bxx, exp_b1[i]);
      check({tag, "_err_sticky"}, err_sticky, model_err);
      exp_b0.delete(); exp_b1.delete(); got_b0.delete(); got_b1.delete();
   endtask

   task automatic reset_pulse(input string tag);
      @(negedge ap_clk);
      ap_rst_n = 1'b0;
      repeat (2) @(posedge ap_clk);
      #2;
      clear_model();
      check_reset_outputs(tag);
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
   endtask

   // Bus-functional requesters, memory slave and monitor. Handshakes are judged at
   // the negedge (inputs are stable until the next edge), inputs change at posedge+1.
   initial begin : bfm
      logic awf0, awf1, wf0, wf1, bf0, bf1, maw, mw, mb, m_aw_v, prev_req;
      logic [1:0] br0, br1, cur_grant;
      burst_t e;
      beat_t  w;
      prev_req = 1'b0;
      cur_grant = 2'b00;
      forever begin
         @(negedge ap_clk);
         awf0 = s0_axi_awvalid && s0_axi_awready;  awf1 = s1_axi_awvalid && s1_axi_awready;
         wf0  = s0_axi_wvalid && s0_axi_wready;    wf1  = s1_axi_wvalid && s1_axi_wready;
         bf0  = s0_axi_bvalid && s0_axi_bready;    bf1  = s1_axi_bvalid && s1_axi_bready;
         br0  = s0_axi_bresp;                      br1  = s1_axi_bresp;
         maw  = m_axi_awvalid && m_axi_awready;
         mw   = m_axi_wvalid && m_axi_wready;
         mb   = m_axi_bvalid && m_axi_bready;
         m_aw_v = m_axi_awvalid;
         if (ap_rst_n) begin
            if (prev_req) check("aw_latency", m_axi_awvalid, 1);
            prev_req = !busy && (s0_axi_awvalid || s1_axi_awvalid);
            check("busy_vs_grant", busy, (grant != 2'b00));
            if (!grant[0]) check("s0_quiet", {s0_axi_awready, s0_axi_wready, s0_axi_bvalid, s0_axi_bresp}, 0);
            if (!grant[1]) check("s1_quiet", {s1_axi_awready, s1_axi_wready, s1_axi_bvalid, s1_axi_bresp}, 0);
            if (maw) begin
               check("aw_expected", (exp_aw.size() > 0), 1);
               if (exp_aw.size() > 0) begin
                  e = exp_aw.pop_front();
                  cur_grant = exp_grant.pop_front();
                  check("aw_grant", grant, cur_grant);
                  check("aw_addr", m_axi_awaddr, e.addr);
                  check("aw_attr", {m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awprot},
                        {e.len, e.size, e.burst, e.prot});
               end
            end
            if (mw) begin
               beats_seen++;
               check("w_expected", (exp_w.size() > 0), 1);
               if (exp_w.size() > 0) begin
                  w = exp_w.pop_front();
                  check("w_grant", grant, cur_grant);
                  check("w_beat", {m_axi_wdata, m_axi_wstrb, m_axi_wlast}, {w.data, w.strb, w.last});
               end
            end
         end else begin
            prev_req = 1'b0;
         end
         @(posedge ap_clk);
         #1;
         if (!ap_rst_n) begin
            awq0.delete(); awq1.delete(); wq0.delete(); wq1.delete();
            pending_b = 0;
            s0_axi_awvalid = 0; s1_axi_awvalid = 0; s0_axi_wvalid = 0; s1_axi_wvalid = 0;
            m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
            continue;
         end
         // requester 0
         if (awf0) void'(awq0.pop_front());
         s0_axi_awvalid = (awq0.size() > 0);
         if (awq0.size() > 0) begin
            s0_axi_awaddr = awq0[0].addr; s0_axi_awlen = awq0[0].len; s0_axi_awsize = awq0[0].size;
            s0_axi_awburst = awq0[0].burst; s0_axi_awprot = awq0[0].prot;
         end
         if (wf0) void'(wq0.pop_front());
         if (wq0.size() == 0) s0_axi_wvalid = 0;
         else if (!(s0_axi_wvalid && !wf0)) s0_axi_wvalid = ($urandom_range(0, 3) != 0);
         if (wq0.size() > 0) begin
            s0_axi_wdata = wq0[0].data; s0_axi_wstrb = wq0[0].strb; s0_axi_wlast = wq0[0].last;
         end
         if (bf0) got_b0.push_back(br0);
         s0_axi_bready = ($urandom_range(0, 3) != 0);
         // requester 1
         if (awf1) void'(awq1.pop_front());
         s1_axi_awvalid = (awq1.size() > 0);
         if (awq1.size() > 0) begin
            s1_axi_awaddr = awq1[0].addr; s1_axi_awlen = awq1[0].len; s1_axi_awsize = awq1[0].size;
            s1_axi_awburst = awq1[0].burst; s1_axi_awprot = awq1[0].prot;
         end
         if (wf1) void'(wq1.pop_front());
         if (wq1.size() == 0) s1_axi_wvalid = 0;
         else if (!(s1_axi_wvalid && !wf1)) s1_axi_wvalid = ($urandom_range(0, 3) != 0);
         if (wq1.size() > 0) begin
            s1_axi_wdata = wq1[0].data; s1_axi_wstrb = wq1[0].strb; s1_axi_wlast = wq1[0].last;
         end
         if (bf1) got_b1.push_back(br1);
         s1_axi_bready = ($urandom_range(0, 3) != 0);
         // memory slave
         if (mw && m_axi_wlast) pending_b++;
         if (mb) begin
            pending_b--;
            if (resp_tbl.size() > 0) void'(resp_tbl.pop_front());
         end
         if (bp_mode) begin
            if (maw) aw_hold = 5;
            else if (m_aw_v && aw_hold > 0) aw_hold--;
            m_axi_awready = (aw_hold == 0);
            m_axi_wready  = !m_axi_wready;
         end else begin
            m_axi_awready = ($urandom_range(0, 2) != 0);
            m_axi_wready  = ($urandom_range(0, 3) != 0);
         end
         if (!(m_axi_bvalid && !mb))
            m_axi_bvalid = (pending_b > 0) && (resp_tbl.size() > 0) && ($urandom_range(0, 1) == 1);
         m_axi_bresp = m_axi_bvalid ? resp_tbl[0] : 2'b00;
      end
   end

   initial begin : main
      int n, start, nb0, nb1;
      s0_axi_awvalid = 0; s0_axi_awaddr = 0; s0_axi_awlen = 0; s0_axi_awsize = 0; s0_axi_awburst = 0;
      s0_axi_awprot = 0; s0_axi_wvalid = 0; s0_axi_wlast = 0; s0_axi_wdata = 0; s0_axi_wstrb = 0;
      s0_axi_bready = 0;
      s1_axi_awvalid = 0; s1_axi_awaddr = 0; s1_axi_awlen = 0; s1_axi_awsize = 0; s1_axi_awburst = 0;
      s1_axi_awprot = 0; s1_axi_wvalid = 0; s1_axi_wlast = 0; s1_axi_wdata = 0; s1_axi_wstrb = 0;
      s1_axi_bready = 0;
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;

      // Reset state.
      repeat (3) @(posedge ap_clk);
      #2;
      check_reset_outputs("rst0");
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      repeat (2) @(negedge ap_clk);

      // Single requester, 4-beat burst 0x01..0x04.
      add_burst(0, 32'h0000_1000, 8'd3, 8'h01, 2'b00, 0);
      commit();
      wait_done(300, "single");

      // Contention from reset: 0,1,0 order; s1 data 0xAA waits behind s0.
      reset_pulse("rst1");
      add_burst(0, 32'h0000_3000, 8'd2, 8'h10, 2'b00, 0);
      add_burst(0, 32'h0000_5000, 8'd1, 8'h20, 2'b00, 0);
      add_burst(1, 32'h0000_2000, 8'd0, 8'hAA, 2'b00, 0);
      commit();
      repeat (2) @(negedge ap_clk);
      check("contend_first_grant", grant, 2'b01);
      check("contend_first_awvalid", m_axi_awvalid, 1);
      wait_done(500, "contend");

      // Backpressure: awready held off 5 cycles, wready on alternate cycles, 16 beats.
      bp_mode = 1'b1;
      aw_hold = 5;
      add_burst(0, 32'h0000_4000, 8'd15, 8'h00, 2'b00, 1);
      commit();
      wait_done(500, "backpressure");
      bp_mode = 1'b0;

      // Error response on an s1 burst.
      add_burst(1, 32'h0000_6000, 8'd2, 8'h30, 2'b10, 0);
      commit();
      wait_done(300, "slverr");

      // Randomized rounds with mixed lengths, attributes and responses.
      for (int r = 0; r < 5; r++) begin
         nb0 = $urandom_range(0, 3);
         nb1 = $urandom_range(1, 3);
         for (int i = 0; i < nb0; i++)
            add_burst(0, $urandom(), 8'($urandom_range(0, 7)), 8'h00,
                      ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00, 1);
         for (int i = 0; i < nb1; i++)
            add_burst(1, $urandom(), 8'($urandom_range(0, 7)), 8'h00,
                      ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00, 1);
         commit();
         wait_done(2000, "random");
      end

      // Reset asserted in the middle of a data phase.
      add_burst(0, 32'h0000_7000, 8'd7, 8'h00, 2'b00, 1);
      commit();
      start = beats_seen;
      n = 0;
      while (beats_seen < start + 2 && n < 300) begin
         @(negedge ap_clk);
         n++;
      end
      check("mid_data_reached", (beats_seen >= start + 2), 1);
      #2;
      ap_rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      @(posedge ap_clk);
      #2;
      clear_model();
      repeat (2) @(negedge ap_clk);
      check_reset_outputs("rst_hold");
      ap_rst_n = 1'b1;
      repeat (2) @(negedge ap_clk);

      // Recovery: arbitration history is back to requester 0 first.
      add_burst(1, 32'h0000_8000, 8'd1, 8'h40, 2'b00, 0);
      add_burst(0, 32'h0000_9000, 8'd1, 8'h50, 2'b00, 0);
      commit();
      repeat (2) @(negedge ap_clk);
      check("recover_first_grant", grant, 2'b01);
      wait_done(500, "recover");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
